// File: rtl/dma_burst_splitter_pkg.sv
//------------------------------------------------------------------------------
// Module   : dma_burst_splitter_pkg
// Brief    : Shared definitions for the DMA burst splitter and DMA wrapper.
//            Provides direction codes, FSM state encoding and default
//            burst/boundary sizing.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dma_burst_splitter_pkg;

    // Direction encoding seen by the DMA channel
    localparam logic DMA_DIR_WR = 1'b0;
    localparam logic DMA_DIR_RD = 1'b1;

    // Default sizing, shared with the DMA wrapper instance
    localparam int unsigned DEF_MAX_BURST = 256;
    localparam int unsigned DEF_BOUNDARY  = 4096;

    // Splitter FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CALC      = 3'd1,
        ST_REQ       = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FIN       = 3'd4
    } state_t;

endpackage : dma_burst_splitter_pkg

`default_nettype wire

// File: rtl/dma_burst_splitter.sv
//------------------------------------------------------------------------------
// Module   : dma_burst_splitter
// Brief    : Splits one transfer job into DMA requests capped at MAX_BURST
//            bytes that never cross a BOUNDARY-aligned address. Control
//            only; the data path is untouched.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dma_burst_splitter
    import dma_burst_splitter_pkg::*;
#(
    parameter int unsigned MAX_BURST = DEF_MAX_BURST,
    parameter int unsigned BOUNDARY  = DEF_BOUNDARY
) (
    input  logic        clk_100m,
    input  logic        i_reset_n,
    // Job interface
    input  logic        i_job_valid,
    output logic        o_job_ready,
    input  logic        i_job_dir,
    input  logic [31:0] i_job_addr,
    input  logic [31:0] i_job_len,
    output logic        o_job_done,
    output logic        o_job_err,
    // DMA request interface
    output logic        o_req,
    input  logic        i_ack,
    output logic        o_req_dir,
    output logic [31:0] o_req_addr,
    output logic [31:0] o_req_len,
    input  logic        i_req_done,
    // Status
    output logic        o_busy,
    output logic [15:0] o_burst_cnt
);

    localparam logic [31:0] c_max_burst = 32'(MAX_BURST);
    localparam logic [31:0] c_boundary  = 32'(BOUNDARY);
    localparam logic [31:0] c_bound_msk = c_boundary - 32'd1;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_dir;
    logic [31:0] r_cur_addr;
    logic [31:0] r_rem;
    logic [31:0] r_chunk;
    logic        r_done_seen;

    logic        w_accept;
    logic        w_job_bad;
    logic        w_chunk_done;
    logic        w_last_chunk;
    logic [31:0] w_to_bound;
    logic [31:0] w_chunk;

    logic        w_req_nxt;
    logic        w_busy_nxt;
    logic        w_ready_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;

    // A job offered in IDLE is malformed if empty or not word-aligned
    assign w_job_bad    = (i_job_len == 32'd0) || (i_job_addr[1:0] != 2'b00) ||
                          (i_job_len[1:0] != 2'b00);
    assign w_accept     = i_job_valid && (r_state == ST_IDLE);
    // Completion may have been seen together with the ack
    assign w_chunk_done = i_req_done || r_done_seen;
    assign w_last_chunk = (r_rem == r_chunk);

    // Chunk = min(remaining, MAX_BURST, bytes left before next boundary)
    assign w_to_bound = c_boundary - (r_cur_addr & c_bound_msk);
    always_comb begin
        w_chunk = r_rem;
        if (c_max_burst < w_chunk) begin
            w_chunk = c_max_burst;
        end
        if (w_to_bound < w_chunk) begin
            w_chunk = w_to_bound;
        end
    end

    // State register plus registered versions of the state-derived outputs
    always_ff @(posedge clk_100m) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            o_req       <= 1'b0;
            o_busy      <= 1'b0;
            o_job_ready <= 1'b1;
            o_job_done  <= 1'b0;
            o_job_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            o_req       <= w_req_nxt;
            o_busy      <= w_busy_nxt;
            o_job_ready <= w_ready_nxt;
            o_job_done  <= w_done_nxt;
            o_job_err   <= w_err_nxt;
        end
    end

    // Next-state decision
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_job_bad) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (i_ack) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (w_chunk_done) begin
                    w_state_nxt = w_last_chunk ? ST_FIN : ST_CALC;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        w_req_nxt   = (w_state_nxt == ST_REQ);
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_ready_nxt = (w_state_nxt == ST_IDLE);
        w_done_nxt  = (w_state_nxt == ST_FIN);
        w_err_nxt   = w_accept && w_job_bad;
    end

    // Job datapath: latch job, load request fields, advance per chunk
    always_ff @(posedge clk_100m) begin
        if (!i_reset_n) begin
            r_dir       <= DMA_DIR_WR;
            r_cur_addr  <= 32'd0;
            r_rem       <= 32'd0;
            r_chunk     <= 32'd0;
            r_done_seen <= 1'b0;
            o_req_dir   <= DMA_DIR_WR;
            o_req_addr  <= 32'd0;
            o_req_len   <= 32'd0;
            o_burst_cnt <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !w_job_bad) begin
                        r_dir       <= i_job_dir;
                        r_cur_addr  <= i_job_addr;
                        r_rem       <= i_job_len;
                        r_done_seen <= 1'b0;
                        o_burst_cnt <= 16'd0;
                    end
                end
                ST_CALC: begin
                    r_chunk    <= w_chunk;
                    o_req_dir  <= r_dir;
                    o_req_addr <= r_cur_addr;
                    o_req_len  <= w_chunk;
                end
                ST_REQ: begin
                    if (i_ack && i_req_done) begin
                        r_done_seen <= 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (w_chunk_done) begin
                        r_cur_addr  <= r_cur_addr + r_chunk;
                        r_rem       <= r_rem - r_chunk;
                        r_done_seen <= 1'b0;
                        if (o_burst_cnt != 16'hFFFF) begin
                            o_burst_cnt <= o_burst_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : dma_burst_splitter

`default_nettype wire

// File: tb/tb_dma_burst_splitter.sv
//------------------------------------------------------------------------------
// Module   : tb_dma_burst_splitter
// Brief    : Directed self-checking bench for dma_burst_splitter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dma_burst_splitter;

    logic        clk_100m = 1'b0;
    logic        i_reset_n;
    logic        i_job_valid;
    logic        o_job_ready;
    logic        i_job_dir;
    logic [31:0] i_job_addr;
    logic [31:0] i_job_len;
    logic        o_job_done;
    logic        o_job_err;
    logic        o_req;
    logic        i_ack;
    logic        o_req_dir;
    logic [31:0] o_req_addr;
    logic [31:0] o_req_len;
    logic        i_req_done;
    logic        o_busy;
    logic [15:0] o_burst_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk_100m = ~clk_100m;

    dma_burst_splitter #(
        .MAX_BURST (256),
        .BOUNDARY  (4096)
    ) u_dut (
        .clk_100m    (clk_100m),
        .i_reset_n   (i_reset_n),
        .i_job_valid (i_job_valid),
        .o_job_ready (o_job_ready),
        .i_job_dir   (i_job_dir),
        .i_job_addr  (i_job_addr),
        .i_job_len   (i_job_len),
        .o_job_done  (o_job_done),
        .o_job_err   (o_job_err),
        .o_req       (o_req),
        .i_ack       (i_ack),
        .o_req_dir   (o_req_dir),
        .o_req_addr  (o_req_addr),
        .o_req_len   (o_req_len),
        .i_req_done  (i_req_done),
        .o_busy      (o_busy),
        .o_burst_cnt (o_burst_cnt)
    );

    // Offer a job for one cycle; returns at the negedge of the cycle after acceptance
    task automatic start_job(input logic dir, input logic [31:0] addr, input logic [31:0] len);
        i_job_valid = 1'b1;
        i_job_dir   = dir;
        i_job_addr  = addr;
        i_job_len   = len;
        checks++;
        if (o_job_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_ready: got %b want 1", o_job_ready);
        end
        @(negedge clk_100m);
        i_job_valid = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_job_ready !== 1'b0 || o_burst_cnt !== 16'd0) begin
            failures++;
            $display("FAIL accept_state: busy=%b ready=%b cnt=%0d want 1 0 0",
                     o_busy, o_job_ready, o_burst_cnt);
        end
    endtask

    // Act as the DMA channel for one chunk
    task automatic serve_chunk(input logic [31:0] ea, input logic [31:0] el, input logic ed,
                               input int ack_dly, input bit same, input bit last);
        int n = 0;
        while (o_req !== 1'b1 && n < 50) begin
            @(negedge clk_100m);
            n++;
        end
        checks++;
        if (o_req !== 1'b1) begin
            failures++;
            $display("FAIL req_timeout: o_req=%b want 1 within 50 cycles", o_req);
        end
        checks++;
        if (o_req_addr !== ea || o_req_len !== el || o_req_dir !== ed) begin
            failures++;
            $display("FAIL req_fields: addr=%h len=%h dir=%b want %h %h %b",
                     o_req_addr, o_req_len, o_req_dir, ea, el, ed);
        end
        for (int k = 0; k < ack_dly; k++) begin
            @(negedge clk_100m);
            checks++;
            if (o_req !== 1'b1 || o_req_addr !== ea || o_req_len !== el || o_req_dir !== ed) begin
                failures++;
                $display("FAIL req_hold: req=%b addr=%h len=%h dir=%b want 1 %h %h %b",
                         o_req, o_req_addr, o_req_len, o_req_dir, ea, el, ed);
            end
        end
        i_ack      = 1'b1;
        i_req_done = same;
        @(negedge clk_100m);
        i_ack      = 1'b0;
        i_req_done = 1'b0;
        checks++;
        if (o_req !== 1'b0) begin
            failures++;
            $display("FAIL req_drop: o_req=%b want 0", o_req);
        end
        if (!same) begin
            i_req_done = 1'b1;
            @(negedge clk_100m);
            i_req_done = 1'b0;
        end else begin
            @(negedge clk_100m);
        end
        checks++;
        if (o_job_done !== last) begin
            failures++;
            $display("FAIL job_done_pulse: got %b want %b", o_job_done, last);
        end
        if (last) begin
            @(negedge clk_100m);
            checks++;
            if (o_job_done !== 1'b0 || o_job_ready !== 1'b1 || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL job_end: done=%b ready=%b busy=%b want 0 1 0",
                         o_job_done, o_job_ready, o_busy);
            end
        end
    endtask

    task automatic check_cnt(input logic [15:0] exp);
        checks++;
        if (o_burst_cnt !== exp) begin
            failures++;
            $display("FAIL burst_cnt: got %0d want %0d", o_burst_cnt, exp);
        end
    endtask

    task automatic test_reset();
        i_reset_n   = 1'b0;
        i_job_valid = 1'b0;
        i_job_dir   = 1'b0;
        i_job_addr  = 32'd0;
        i_job_len   = 32'd0;
        i_ack       = 1'b0;
        i_req_done  = 1'b0;
        repeat (3) @(negedge clk_100m);
        checks++;
        if (o_job_ready !== 1'b1 || o_job_done !== 1'b0 || o_job_err !== 1'b0 ||
            o_req !== 1'b0 || o_req_dir !== 1'b0 || o_busy !== 1'b0 ||
            o_req_addr !== 32'd0 || o_req_len !== 32'd0 || o_burst_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_values: ready=%b done=%b err=%b req=%b dir=%b busy=%b addr=%h len=%h cnt=%0d",
                     o_job_ready, o_job_done, o_job_err, o_req, o_req_dir, o_busy,
                     o_req_addr, o_req_len, o_burst_cnt);
        end
        i_reset_n = 1'b1;
        @(negedge clk_100m);
    endtask

    task automatic test_single_chunk();
        start_job(1'b0, 32'h0000_0100, 32'h40);
        // CALC cycle: no request yet; request appears one cycle later
        checks++;
        if (o_req !== 1'b0) begin
            failures++;
            $display("FAIL calc_latency: o_req=%b want 0", o_req);
        end
        @(negedge clk_100m);
        checks++;
        if (o_req !== 1'b1) begin
            failures++;
            $display("FAIL req_latency: o_req=%b want 1", o_req);
        end
        serve_chunk(32'h100, 32'h40, 1'b0, 0, 1'b0, 1'b1);
        check_cnt(16'd1);
    endtask

    task automatic test_multi_chunk();
        start_job(1'b1, 32'h100, 32'd600);
        serve_chunk(32'h100, 32'd256, 1'b1, 0, 1'b0, 1'b0);
        serve_chunk(32'h200, 32'd256, 1'b1, 1, 1'b0, 1'b0);
        serve_chunk(32'h300, 32'd88,  1'b1, 0, 1'b0, 1'b1);
        check_cnt(16'd3);
    endtask

    task automatic test_boundary();
        start_job(1'b0, 32'h0FC0, 32'h100);
        serve_chunk(32'h0FC0, 32'h40, 1'b0, 0, 1'b0, 1'b0);
        serve_chunk(32'h1000, 32'hC0, 1'b0, 0, 1'b0, 1'b1);
        check_cnt(16'd2);
    endtask

    task automatic test_addr_wrap();
        start_job(1'b1, 32'hFFFF_FF00, 32'h200);
        serve_chunk(32'hFFFF_FF00, 32'h100, 1'b1, 0, 1'b0, 1'b0);
        serve_chunk(32'h0000_0000, 32'h100, 1'b1, 0, 1'b0, 1'b1);
        check_cnt(16'd2);
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3];
        logic [31:0] lens  [3];
        addrs[0] = 32'h0;  lens[0] = 32'd0;
        addrs[1] = 32'h2;  lens[1] = 32'd4;
        addrs[2] = 32'h0;  lens[2] = 32'd6;
        for (int i = 0; i < 3; i++) begin
            i_job_valid = 1'b1;
            i_job_addr  = addrs[i];
            i_job_len   = lens[i];
            @(negedge clk_100m);
            i_job_valid = 1'b0;
            checks++;
            if (o_job_err !== 1'b1 || o_job_ready !== 1'b1 || o_busy !== 1'b0 || o_req !== 1'b0) begin
                failures++;
                $display("FAIL job_err[%0d]: err=%b ready=%b busy=%b req=%b want 1 1 0 0",
                         i, o_job_err, o_job_ready, o_busy, o_req);
            end
            @(negedge clk_100m);
            checks++;
            if (o_job_err !== 1'b0 || o_req !== 1'b0 || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL job_err_end[%0d]: err=%b req=%b busy=%b want 0 0 0",
                         i, o_job_err, o_req, o_busy);
            end
        end
    endtask

    task automatic test_ack_delay();
        start_job(1'b0, 32'h2000, 32'h80);
        serve_chunk(32'h2000, 32'h80, 1'b0, 5, 1'b0, 1'b1);
        check_cnt(16'd1);
    endtask

    task automatic test_ack_done_same();
        start_job(1'b1, 32'h3000, 32'h20);
        serve_chunk(32'h3000, 32'h20, 1'b1, 2, 1'b1, 1'b1);
        check_cnt(16'd1);
    endtask

    task automatic test_back_to_back();
        // Job starts in the first cycle o_job_ready is back
        start_job(1'b0, 32'h4000, 32'h10);
        serve_chunk(32'h4000, 32'h10, 1'b0, 0, 1'b0, 1'b1);
        start_job(1'b0, 32'h5000, 32'h180);
        serve_chunk(32'h5000, 32'h100, 1'b0, 0, 1'b0, 1'b0);
        serve_chunk(32'h5100, 32'h80,  1'b0, 0, 1'b0, 1'b1);
        check_cnt(16'd2);
    endtask

    task automatic test_reset_wait_done();
        int n = 0;
        start_job(1'b1, 32'h6000, 32'h40);
        while (o_req !== 1'b1 && n < 50) begin
            @(negedge clk_100m);
            n++;
        end
        i_ack = 1'b1;
        @(negedge clk_100m);
        i_ack     = 1'b0;
        i_reset_n = 1'b0;
        @(negedge clk_100m);
        i_reset_n = 1'b1;
        checks++;
        if (o_req !== 1'b0 || o_busy !== 1'b0 || o_job_ready !== 1'b1 ||
            o_job_done !== 1'b0 || o_burst_cnt !== 16'd0 || o_req_addr !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid: req=%b busy=%b ready=%b done=%b cnt=%0d addr=%h want 0 0 1 0 0 0",
                     o_req, o_busy, o_job_ready, o_job_done, o_burst_cnt, o_req_addr);
        end
        // A late completion for the abandoned transfer must be ignored
        i_req_done = 1'b1;
        @(negedge clk_100m);
        i_req_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_job_done !== 1'b0 || o_busy !== 1'b0 || o_burst_cnt !== 16'd0) begin
                failures++;
                $display("FAIL stale_done[%0d]: done=%b busy=%b cnt=%0d want 0 0 0",
                         k, o_job_done, o_busy, o_burst_cnt);
            end
            @(negedge clk_100m);
        end
    endtask

    initial begin
        test_reset();
        test_single_chunk();
        test_multi_chunk();
        test_boundary();
        test_addr_wrap();
        test_errors();
        test_ack_delay();
        test_ack_done_same();
        test_back_to_back();
        test_reset_wait_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_dma_burst_splitter

`default_nettype wire

// File: doc/dma_burst_splitter.md
# dma_burst_splitter

Control-only stage directly upstream of a DMA read/write channel (req/ack/addr/len/req_done protocol) on the DDR user side. It accepts one transfer job (direction, byte address, byte length) and splits it into successive DMA requests. Each request is capped at MAX_BURST bytes and never crosses a BOUNDARY-aligned address. The data path is not touched; the block sequences requests only.

## Interface
- MAX_BURST, 256, max bytes per DMA request; power of 2, 4..BOUNDARY
- BOUNDARY, 4096, address boundary no request may cross; power of 2
- clk_100m  in  1  clock
- i_reset_n  in  1  synchronous, active-low reset
- i_job_valid  in  1  job offered
- o_job_ready  out  1  block idle, can accept a job
- i_job_dir  in  1  0 = write, 1 = read
- i_job_addr  in  32  start byte address; must be 4-byte aligned
- i_job_len  in  32  length in bytes; nonzero, multiple of 4
- o_job_done  out  1  1-cycle pulse: all chunks completed
- o_job_err  out  1  1-cycle pulse: job rejected (bad len/alignment)
- o_req  out  1  DMA request
- i_ack  in  1  DMA accepted current request
- o_req_dir  out  1  direction of current request
- o_req_addr  out  32  byte address of current chunk
- o_req_len  out  32  byte length of current chunk
- i_req_done  in  1  1-cycle pulse: current chunk finished
- o_busy  out  1  high whenever state != IDLE
- o_burst_cnt  out  16  chunks completed in current/last job; cleared on job accept; saturates at 0xFFFF

## Operation
- States: IDLE, CALC, REQ, WAIT_DONE, FIN.
- IDLE: o_job_ready = 1. On i_job_valid & o_job_ready, the job is checked.
  - Reject when len == 0, addr[1:0] != 0, or len[1:0] != 0. Reject action: pulse o_job_err next cycle, stay in IDLE, issue no request.
  - Otherwise latch dir, addr to cur_addr, len to rem; clear o_burst_cnt; go to CALC.
- CALC: register chunk = min(rem, MAX_BURST, BOUNDARY − (cur_addr mod BOUNDARY)). Load o_req_addr = cur_addr and o_req_len = chunk. Go to REQ.
- REQ: o_req = 1. o_req_dir, o_req_addr and o_req_len stay stable until i_ack is sampled high, then go to WAIT_DONE with o_req = 0.
  - i_req_done sampled in the same cycle as i_ack is latched into done_seen and counts as completion.
- WAIT_DONE: on i_req_done or done_seen:
  - cur_addr += chunk, modulo 2^32 (wraps naturally).
  - rem −= chunk.
  - o_burst_cnt += 1.
  - Go to FIN if rem == 0, else to CALC.
- i_req_done outside REQ/WAIT_DONE is ignored.
- FIN: o_job_done = 1 for one cycle, then go to IDLE.
- i_job_valid while busy is ignored; o_job_ready = 0.
- All arithmetic is 32-bit unsigned. The chunk is always ≥ 4 and a multiple of 4, because BOUNDARY and MAX_BURST are multiples of 4 and addr/len are aligned.

## Timing
- Reset values: o_job_ready = 1 (state IDLE); o_job_done, o_job_err, o_req, o_req_dir, o_busy = 0; o_req_addr, o_req_len, o_burst_cnt = 0.
- Reset asserted mid-operation, in any state: all of the above apply at the next edge. A pending DMA transfer is abandoned, with no done or err pulse.
- Job accepted at edge T: CALC during T+1, o_req high from T+2.
- i_ack sampled at edge A: o_req low from A+1.
- Last i_req_done at edge D: o_job_done high during D+1; o_job_ready high from D+2.
- Non-final i_req_done at edge D: next o_req high from D+2 (one CALC cycle).
- Rejected job at edge T: o_job_err high during T+1; o_job_ready stays 1.
- All outputs are registered.

## Structure
- Shared package: DMA_DIR_WR/DMA_DIR_RD constants, the state enum encoding, and a default MAX_BURST/BOUNDARY pair, all shared with the DMA wrapper instance.
- Single module; no sub-module. The min-of-three chunk calculation is inline combinational logic feeding the CALC register.

## Test plan
- Single chunk: addr 0x0000_0100, len 0x40, write → one request (0x100, 0x40, dir 0). o_job_done 1 cycle after its i_req_done; o_burst_cnt = 1.
- Multi chunk: addr 0x100, len 600, read → requests (0x100, 256), (0x200, 256), (0x300, 88); o_burst_cnt = 3.
- Boundary crossing: addr 0x0FC0, len 0x100 → (0x0FC0, 0x40), (0x1000, 0xC0).
- Address wrap: addr 0xFFFF_FF00, len 0x200 → (0xFFFF_FF00, 0x100), (0x0000_0000, 0x100).
- Errors: len 0, then addr 0x2/len 4, then len 6 → three o_job_err pulses; o_req never asserted.
- Handshake/reset:
  - i_ack delayed 5 cycles → o_req, o_req_addr and o_req_len held stable.
  - i_ack and i_req_done in the same cycle → counted once.
  - Reset during WAIT_DONE → o_req = 0, o_busy = 0, o_job_ready = 1 next cycle, no o_job_done.
